updown_counter: RTL and testbench

Parametrised synchronous up/down modulo counter, the successor to the team's fixed 4-bit free-running down counter. It adds configurable width and modulus, run-time direction, enable, synchronous clear and load, and a wrap-or-saturate mode. It provides a combinational terminal-count output for cascading and a registered wrap pulse for event logging. It sits in the counters library and is used as a timer base and as a cascadable digit in multi-stage counters.

---
 rtl/updown_counter.sv | 87 ++++++++
 tb/tb_updown_counter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/updown_counter.sv
// updown_counter: parametrised up/down modulo counter with wrap or
// saturate, cascade terminal count and a registered wrap pulse.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (count=RESET_VAL)
//   clr       synchronous clear to 0 (highest priority)
//   load      synchronous load of load_val, clamped to MOD-1
//   load_val  value to load
//   en        count enable
//   up        direction, 1 = increment, 0 = decrement
//   count     registered count, always within 0..MOD-1
//   tc        combinational terminal count for cascading
//   wrapped   registered copy of tc, one cycle late
module updown_counter #(
    parameter int unsigned     WIDTH     = 4,
    parameter longint unsigned MOD       = 16,
    parameter longint unsigned RESET_VAL = MOD - 1,
    parameter bit              SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrapped
);

    // One extra bit so MOD = 2^WIDTH and clamping compare cleanly.
    localparam logic [WIDTH:0]   MAXV = (WIDTH+1)'(MOD - 1);
    localparam logic [WIDTH:0]   ONE  = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] RSTV = WIDTH'(RESET_VAL);

    logic [WIDTH:0] cur;
    logic [WIDTH:0] lv;
    logic [WIDTH:0] inc;
    logic [WIDTH:0] dec;
    logic [WIDTH:0] nxt;
    logic           at_max;
    logic           at_zero;
    logic           term;
    logic           unused_carry;

    assign cur     = {1'b0, count};
    assign lv      = {1'b0, load_val};
    assign inc     = cur + ONE;
    assign dec     = cur - ONE;
    assign at_max  = (cur == MAXV);
    assign at_zero = (cur == '0);
    assign term    = up ? at_max : at_zero;

    // Still raised in saturate mode so a following stage sees
    // the boundary; clr/load override counting and mask it.
    assign tc = en & ~clr & ~load & term;

    always_comb begin
        nxt = cur;
        if (clr) begin
            nxt = '0;
        end else if (load) begin
            nxt = (lv > MAXV) ? MAXV : lv;
        end else if (en) begin
            if (up) begin
                nxt = at_max ? (SATURATE ? MAXV : '0) : inc;
            end else begin
                nxt = at_zero ? (SATURATE ? '0 : MAXV) : dec;
            end
        end
    end

    // nxt never exceeds MAXV, so its top bit is always zero.
    assign unused_carry = nxt[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= RSTV;
            wrapped <= 1'b0;
        end else begin
            count   <= nxt[WIDTH-1:0];
            wrapped <= tc;
        end
    end

endmodule

// File: tb/tb_updown_counter.sv
// tb_updown_counter: directed-vector scoreboard bench for
// updown_counter (wrap, saturate, priority, cascade, reset).
module tb_updown_counter;

    typedef struct {
        int       id;
        logic [3:0] cnt;
        logic     tc;
        logic     wr;
        string    nm;
    } exp_t;

    logic clk = 1'b0;
    logic run = 1'b1;
    logic rst_n = 1'b0;

    logic       clr_i [4];
    logic       load_i[4];
    logic [3:0] lv_i  [4];
    logic       en_i  [4];
    logic       up_i  [4];

    logic [3:0] cnt_o[5];
    logic       tc_o [5];
    logic       wr_o [5];

    exp_t q[$];
    event mon_ev;
    int   tests = 0;
    int   fails = 0;

    always #5 if (run) clk = ~clk;

    updown_counter #(.WIDTH(4)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr_i[0]), .load(load_i[0]),
        .load_val(lv_i[0]), .en(en_i[0]), .up(up_i[0]),
        .count(cnt_o[0]), .tc(tc_o[0]), .wrapped(wr_o[0]));

    updown_counter #(.WIDTH(4), .MOD(10), .RESET_VAL(0)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr_i[1]), .load(load_i[1]),
        .load_val(lv_i[1]), .en(en_i[1]), .up(up_i[1]),
        .count(cnt_o[1]), .tc(tc_o[1]), .wrapped(wr_o[1]));

    updown_counter #(.WIDTH(4), .MOD(10), .SATURATE(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .clr(clr_i[2]), .load(load_i[2]),
        .load_val(lv_i[2]), .en(en_i[2]), .up(up_i[2]),
        .count(cnt_o[2]), .tc(tc_o[2]), .wrapped(wr_o[2]));

    updown_counter #(.WIDTH(4), .MOD(10)) c0 (
        .clk(clk), .rst_n(rst_n), .clr(clr_i[3]), .load(load_i[3]),
        .load_val(lv_i[3]), .en(en_i[3]), .up(up_i[3]),
        .count(cnt_o[3]), .tc(tc_o[3]), .wrapped(wr_o[3]));

    updown_counter #(.WIDTH(4), .MOD(10)) c1 (
        .clk(clk), .rst_n(rst_n), .clr(clr_i[3]), .load(1'b0),
        .load_val(4'd0), .en(tc_o[3]), .up(up_i[3]),
        .count(cnt_o[4]), .tc(tc_o[4]), .wrapped(wr_o[4]));

    // Monitor: pops expectations and compares against the DUT.
    initial begin
        exp_t e;
        forever begin
            @(mon_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if (cnt_o[e.id] !== e.cnt || tc_o[e.id] !== e.tc ||
                    wr_o[e.id] !== e.wr) begin
                    fails++;
                    $display("FAIL %s: count=%0d tc=%0b wrapped=%0b, expected count=%0d tc=%0b wrapped=%0b",
                             e.nm, cnt_o[e.id], tc_o[e.id], wr_o[e.id],
                             e.cnt, e.tc, e.wr);
                end
            end
        end
    end

    task automatic chk(input int id, input logic [3:0] c,
                       input logic t, input logic w, input string nm);
        exp_t e;
        e.id = id; e.cnt = c; e.tc = t; e.wr = w; e.nm = nm;
        q.push_back(e);
        -> mon_ev;
        #0;
    endtask

    task automatic vec(input int id, input logic c, input logic l,
                       input logic [3:0] v, input logic e,
                       input logic u, input logic [3:0] xc,
                       input logic xt, input logic xw, input string nm);
        @(negedge clk);
        clr_i[id] = c; load_i[id] = l; lv_i[id] = v;
        en_i[id] = e; up_i[id] = u;
        #1;
        chk(id, xc, xt, xw, nm);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            clr_i[i] = 0; load_i[i] = 0; lv_i[i] = 0;
            en_i[i] = 0; up_i[i] = 0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Default 16-state down counter from reset value 15.
        for (int k = 0; k <= 16; k++)
            vec(0, 0, 0, 0, 1, 0, (k <= 15) ? 4'(15 - k) : 4'd15,
                k == 15, k == 16, $sformatf("down_%0d", k));
        vec(0, 0, 0, 0, 0, 0, 14, 0, 0, "down_hold");

        // Up wrap at modulus 10, then reverse direction at 3.
        for (int k = 0; k <= 12; k++)
            vec(1, 0, 0, 0, 1, 1, 4'(k % 10), k == 9, k == 10,
                $sformatf("mod10_up_%0d", k));
        vec(1, 0, 0, 0, 1, 0, 3, 0, 0, "mod10_dn3");
        vec(1, 0, 0, 0, 1, 0, 2, 0, 0, "mod10_dn2");
        vec(1, 0, 0, 0, 1, 0, 1, 0, 0, "mod10_dn1");
        vec(1, 0, 0, 0, 1, 0, 0, 1, 0, "mod10_dn0");
        vec(1, 0, 0, 0, 1, 0, 9, 0, 1, "mod10_dn9");
        vec(1, 0, 0, 0, 0, 0, 8, 0, 0, "mod10_hold");

        // Priority and clamp on the MOD=10 wrapping counter.
        vec(1, 1, 1, 5, 1, 1, 8, 0, 0, "clr_load");
        vec(1, 0, 1, 12, 0, 1, 0, 0, 0, "clr_wins");
        vec(1, 0, 0, 0, 0, 1, 9, 0, 0, "clamp_12");
        vec(1, 0, 1, 4, 1, 1, 9, 0, 0, "load_at_tc");
        vec(1, 0, 1, 10, 0, 1, 4, 0, 0, "load_taken");
        vec(1, 0, 0, 0, 0, 1, 9, 0, 0, "clamp_10");
        vec(1, 1, 0, 0, 1, 1, 9, 0, 0, "clr_en");
        vec(1, 0, 0, 0, 1, 0, 0, 1, 0, "clr_res");
        vec(1, 0, 0, 0, 0, 0, 9, 0, 1, "clr_wrap");

        // Saturating MOD=10 counter, reset value 9.
        vec(2, 0, 1, 8, 0, 1, 9, 0, 0, "sat_load8");
        vec(2, 0, 0, 0, 1, 1, 8, 0, 0, "sat_8");
        vec(2, 0, 0, 0, 1, 1, 9, 1, 0, "sat_9a");
        vec(2, 0, 0, 0, 1, 1, 9, 1, 1, "sat_9b");
        vec(2, 0, 0, 0, 1, 1, 9, 1, 1, "sat_9c");
        vec(2, 0, 0, 0, 1, 0, 9, 0, 1, "sat_rev");
        vec(2, 0, 1, 1, 0, 0, 8, 0, 0, "sat_down8");
        vec(2, 0, 0, 0, 1, 0, 1, 0, 0, "sat_1");
        vec(2, 0, 0, 0, 1, 0, 0, 1, 0, "sat_0a");
        vec(2, 0, 0, 0, 1, 0, 0, 1, 1, "sat_0b");
        vec(2, 0, 0, 0, 1, 1, 0, 0, 1, "sat_rev0");
        vec(2, 0, 0, 0, 0, 1, 1, 0, 0, "sat_up1");

        // Two-digit decimal cascade from 00 through 100 steps.
        vec(3, 1, 0, 0, 0, 1, 9, 0, 0, "cas_clr");
        for (int k = 0; k <= 100; k++) begin
            @(negedge clk);
            clr_i[3] = 0; en_i[3] = 1; up_i[3] = 1;
            #1;
            chk(3, 4'(k % 10), (k % 10) == 9,
                k > 0 && ((k - 1) % 10) == 9,
                $sformatf("cas0_%0d", k));
            chk(4, 4'((k % 100) / 10), (k % 100) == 99,
                k > 0 && ((k - 1) % 100) == 99,
                $sformatf("cas1_%0d", k));
        end

        // Asynchronous reset with the clock stopped, mid-wrap.
        @(negedge clk);
        en_i[3] = 0;
        en_i[1] = 1; up_i[1] = 1;
        run = 1'b0;
        #1;
        chk(1, 9, 1, 0, "pre_rst_tc");
        #2 rst_n = 1'b0;
        #1;
        chk(0, 15, 0, 0, "rst_u0");
        chk(1, 0, 0, 0, "rst_u1");
        chk(2, 9, 0, 0, "rst_u2");
        chk(3, 9, 0, 0, "rst_c0");
        chk(4, 9, 0, 0, "rst_c1");
        run = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk(1, 0, 0, 0, "rst_held");
        rst_n = 1'b1;
        vec(1, 0, 0, 0, 1, 1, 1, 0, 0, "post_rst1");
        vec(1, 0, 0, 0, 1, 1, 2, 0, 0, "post_rst2");

        #1;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
